aes128_iter_encryptor: RTL

- Sequential AES-128 encryption core that replaces the fully combinational chain of ten rounds with an iterative datapath.
- It performs UNROLL rounds per clock and expands round keys on the fly, so no ten-key table is stored.
- Valid/ready handshakes on input and output let it sit between a plaintext source and a ciphertext sink in the CryptArch datapath.
- Byte order: FIPS-197. Bits [127:120] are state byte 0, and the state is filled column-major.

---
 rtl/aes128_iter_encryptor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_encryptor.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock with round keys expanded on the fly.
// Optional AES_CTR_EN adds a counter register and ctr_load port for CTR-mode keystream use.

module aes128_round (
  input  logic [127:0] st_in,
  input  logic [127:0] rkey_in,
  input  logic [7:0]   rcon_in,
  input  logic         last,
  output logic [127:0] st_out,
  output logic [127:0] rkey_out,
  output logic [7:0]   rcon_out
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] sb [16];
  logic [7:0] shr [16];
  logic [7:0] mix [16];
  logic [31:0] rot, sub, w0, w1, w2, w3;

  // Key schedule: RotWord, SubWord, rcon, then chained xor across the words.
  assign rot = {rkey_in[23:0], rkey_in[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign w0  = rkey_in[127:96] ^ sub ^ {rcon_in, 24'h0};
  assign w1  = rkey_in[95:64] ^ w0;
  assign w2  = rkey_in[63:32] ^ w1;
  assign w3  = rkey_in[31:0] ^ w2;
  assign rkey_out = {w0, w1, w2, w3};
  assign rcon_out = xt(rcon_in);

  // Byte i sits at column i/4, row i%4; ShiftRows rotates row r left by r columns.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sb[i]  = sbox(st_in[127-8*i -: 8]);
    assign shr[i] = sb[4*(((i/4) + (i%4)) % 4) + (i%4)];
    assign st_out[127-8*i -: 8] = (last ? shr[i] : mix[i]) ^ rkey_out[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix[4*c+0] = xt(shr[4*c]) ^ xt(shr[4*c+1]) ^ shr[4*c+1] ^ shr[4*c+2] ^ shr[4*c+3];
    assign mix[4*c+1] = shr[4*c] ^ xt(shr[4*c+1]) ^ xt(shr[4*c+2]) ^ shr[4*c+2] ^ shr[4*c+3];
    assign mix[4*c+2] = shr[4*c] ^ shr[4*c+1] ^ xt(shr[4*c+2]) ^ xt(shr[4*c+3]) ^ shr[4*c+3];
    assign mix[4*c+3] = xt(shr[4*c]) ^ shr[4*c] ^ shr[4*c+1] ^ shr[4*c+2] ^ xt(shr[4*c+3]);
  end
endmodule

module aes128_iter_encryptor #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES_CTR_EN
  ,
  input  logic         ctr_load
`endif
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_iter_encryptor: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [127:0] st, rkey, ct, blk, result;
  logic [7:0]   rcon;
  logic [3:0]   rnd, rnd_nxt;
  logic         accept, enc;
  logic [UNROLL:0][127:0] st_ch, key_ch;
  logic [UNROLL:0][7:0]   rc_ch;

  assign st_ch[0]  = st;
  assign key_ch[0] = rkey;
  assign rc_ch[0]  = rcon;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic last;
    assign last = (rnd + 4'(g)) == 4'd9;
    aes128_round u_round (
      .st_in   (st_ch[g]),
      .rkey_in (key_ch[g]),
      .rcon_in (rc_ch[g]),
      .last    (last),
      .st_out  (st_ch[g+1]),
      .rkey_out(key_ch[g+1]),
      .rcon_out(rc_ch[g+1])
    );
  end

  assign rnd_nxt = rnd + 4'(UNROLL);
  assign accept  = in_valid && in_ready;

`ifdef AES_CTR_EN
  logic [127:0] ctr, pad;
  assign enc    = accept && !ctr_load;
  assign blk    = ctr;
  assign result = st_ch[UNROLL] ^ pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
      pad <= '0;
    end else if (accept && ctr_load) begin
      ctr <= plaintext;
    end else if (enc) begin
      pad <= plaintext;
      ctr <= ctr + 128'd1;
    end
  end
`else
  assign enc    = accept;
  assign blk    = plaintext;
  assign result = st_ch[UNROLL];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (enc) state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd_nxt == 4'd10) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= '0;
      rkey <= '0;
      ct   <= '0;
      rcon <= 8'h01;
      rnd  <= '0;
    end else if (state == IDLE && enc) begin
      st   <= blk ^ key;
      rkey <= key;
      rcon <= 8'h01;
      rnd  <= '0;
    end else if (state == ROUND) begin
      st   <= st_ch[UNROLL];
      rkey <= key_ch[UNROLL];
      rcon <= rc_ch[UNROLL];
      rnd  <= rnd_nxt;
      if (rnd_nxt == 4'd10) ct <= result;
    end
  end

  assign ciphertext = ct;
endmodule
